// File: rtl/tabela_pkg.sv
// rtl/tabela_pkg.sv - shared types and defaults for the tabela truth-table unit
package tabela_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  // s = x'w + yz + xw' with index {x,y,w,z}, x MSB
  localparam logic [15:0] INIT_DEFAULT = 16'hB3EC;

endpackage

// File: rtl/tabela_seq_if.sv
// rtl/tabela_seq_if.sv - control/result bundle of the tabela truth-table unit
interface tabela_seq_if #(
  parameter int N = 4
);
  localparam int TW = 1 << N;

  logic          load;
  logic [TW-1:0] tbl_in;
  logic          mode;
  logic          start;
  logic [N-1:0]  x;
  logic          s;
  logic [N-1:0]  vec;
  logic          s_valid;
  logic          busy;
  logic          done;
  logic [N:0]    ones;
  logic [TW-1:0] result;

  modport master (
    output load, tbl_in, mode, start, x,
    input  s, vec, s_valid, busy, done, ones, result
  );

  modport slave (
    input  load, tbl_in, mode, start, x,
    output s, vec, s_valid, busy, done, ones, result
  );
endinterface

// File: rtl/tabela_lut.sv
// rtl/tabela_lut.sv - combinational TW:1 table lookup
module tabela_lut #(
  parameter int N = 4
) (
  input  logic [(1<<N)-1:0] tbl,
  input  logic [N-1:0]      idx,
  output logic              bit_o
);

  assign bit_o = tbl[idx];

endmodule

// File: rtl/tabela_seq.sv
// rtl/tabela_seq.sv - loadable N-input truth table with direct and sweep evaluation
module tabela_seq
  import tabela_pkg::*;
#(
  parameter int                 N    = 4,
  parameter logic [(1<<N)-1:0]  INIT = INIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  tabela_seq_if.slave bus
);

  localparam int TW = 1 << N;

  state_e        state_q, state_d;
  logic [N-1:0]  cnt_q, cnt_d;
  logic [TW-1:0] tbl_q, tbl_d;
  logic          s_q, s_d;
  logic [N-1:0]  vec_q, vec_d;
  logic          s_valid_q, s_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [N:0]    ones_q, ones_d;
  logic [TW-1:0] result_q, result_d;

  logic [N-1:0]  lut_idx;
  logic          lut_bit;

  // One lookup serves both modes: the sweep counter owns it while sweeping.
  assign lut_idx = (state_q == SWEEP) ? cnt_q : bus.x;

  tabela_lut #(.N(N)) u_lut (
    .tbl   (tbl_q),
    .idx   (lut_idx),
    .bit_o (lut_bit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tbl_d     = tbl_q;
    s_d       = s_q;
    vec_d     = vec_q;
    s_valid_d = s_valid_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ones_d    = ones_q;
    result_d  = result_q;

    case (state_q)
      IDLE: begin
        if (bus.load) begin
          tbl_d = bus.tbl_in;
        end
        if (!bus.mode) begin
          s_d       = lut_bit;
          vec_d     = bus.x;
          s_valid_d = 1'b1;
        end else begin
          s_valid_d = 1'b0;
          if (bus.start) begin
            state_d  = SWEEP;
            cnt_d    = '0;
            busy_d   = 1'b1;
            ones_d   = '0;
            result_d = '0;
          end
        end
      end

      SWEEP: begin
        s_d               = lut_bit;
        vec_d             = cnt_q;
        s_valid_d         = 1'b1;
        result_d[cnt_q]   = lut_bit;
        ones_d            = ones_q + {{N{1'b0}}, lut_bit};
        cnt_d             = cnt_q + {{(N-1){1'b0}}, 1'b1};
        if (cnt_q == N'(TW - 1)) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      tbl_q     <= INIT;
      s_q       <= 1'b0;
      vec_q     <= '0;
      s_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ones_q    <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tbl_q     <= tbl_d;
      s_q       <= s_d;
      vec_q     <= vec_d;
      s_valid_q <= s_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ones_q    <= ones_d;
      result_q  <= result_d;
    end
  end

  assign bus.s       = s_q;
  assign bus.vec     = vec_q;
  assign bus.s_valid = s_valid_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ones    = ones_q;
  assign bus.result  = result_q;

endmodule

// File: tb/tb_tabela_seq.sv
// tb/tb_tabela_seq.sv - randomized self-checking bench for tabela_seq
module tb_tabela_seq;

  localparam int N  = 4;
  localparam int TW = 1 << N;
  localparam logic [TW-1:0] INIT_TBL = 16'hB3EC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  int vectors = 0;
  int errors  = 0;

  // Reference: the table as the design should currently hold it.
  logic [TW-1:0] tbl_m = INIT_TBL;

  tabela_seq_if #(.N(N)) bus ();

  tabela_seq #(.N(N), .INIT(INIT_TBL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load   = 1'b0;
    bus.tbl_in = '0;
    bus.mode   = 1'b1;
    bus.start  = 1'b0;
    bus.x      = '0;
  endtask

  task automatic check_cleared(input string tag);
    vectors++;
    if ({bus.s, bus.vec, bus.s_valid, bus.busy, bus.done, bus.ones, bus.result} !== '0) begin
      errors++;
      $display("FAIL %s: s=%b vec=%0d s_valid=%b busy=%b done=%b ones=%0d result=%h, required all zero",
               tag, bus.s, bus.vec, bus.s_valid, bus.busy, bus.done, bus.ones, bus.result);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    tick();
    check_cleared("reset_state");
    rst_n = 1'b1;
    tick();
    vectors++;
    if (bus.s_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: s_valid=%b busy=%b done=%b, required 0 0 0",
               bus.s_valid, bus.busy, bus.done);
    end
    tbl_m = INIT_TBL;
  endtask

  // One direct evaluation; optionally loads a new table on the same edge.
  task automatic direct_eval(input logic [N-1:0] xv, input logic do_load,
                             input logic [TW-1:0] ld_val, input string tag);
    logic exp_s;
    bus.mode   = 1'b0;
    bus.start  = 1'b0;
    bus.x      = xv;
    bus.load   = do_load;
    bus.tbl_in = ld_val;
    exp_s = tbl_m[xv];
    tick();
    if (do_load) tbl_m = ld_val;
    bus.load = 1'b0;
    vectors++;
    if (bus.s !== exp_s || bus.vec !== xv || bus.s_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: x=%0d got s=%b vec=%0d s_valid=%b, required s=%b vec=%0d s_valid=1",
               tag, xv, bus.s, bus.vec, bus.s_valid, exp_s, xv);
    end
  endtask

  task automatic test_direct();
    direct_eval(4'b0101, 1'b0, '0, "direct_x5");
    direct_eval(4'b1010, 1'b0, '0, "direct_x10");
    for (int i = 0; i < 40; i++) begin
      direct_eval(N'($urandom), 1'($urandom), TW'($urandom), "direct_rand");
    end
    direct_eval('0, 1'b1, INIT_TBL, "direct_restore");
  endtask

  // Full sweep from the IDLE state; noise toggles inputs that must be ignored.
  task automatic run_sweep(input logic do_load, input logic [TW-1:0] ld_val,
                           input logic noise, input string tag);
    logic [N:0] exp_ones;
    bus.mode   = 1'b1;
    bus.start  = 1'b1;
    bus.load   = do_load;
    bus.tbl_in = ld_val;
    tick();
    if (do_load) tbl_m = ld_val;
    idle_inputs();
    vectors++;
    if (bus.busy !== 1'b1 || bus.s_valid !== 1'b0 || bus.done !== 1'b0 ||
        bus.ones !== '0 || bus.result !== '0) begin
      errors++;
      $display("FAIL %s_start: busy=%b s_valid=%b done=%b ones=%0d result=%h, required 1 0 0 0 0",
               tag, bus.busy, bus.s_valid, bus.done, bus.ones, bus.result);
    end
    for (int i = 0; i < TW; i++) begin
      if (noise) begin
        bus.load   = 1'b1;
        bus.start  = 1'b1;
        bus.tbl_in = TW'($urandom);
        bus.mode   = 1'($urandom);
        bus.x      = N'($urandom);
      end
      tick();
      vectors++;
      if (bus.s !== tbl_m[i] || bus.vec !== N'(i) || bus.s_valid !== 1'b1 ||
          bus.busy !== (i != TW - 1) || bus.done !== (i == TW - 1)) begin
        errors++;
        $display("FAIL %s_sample: i=%0d got s=%b vec=%0d s_valid=%b busy=%b done=%b, required s=%b vec=%0d 1 %b %b",
                 tag, i, bus.s, bus.vec, bus.s_valid, bus.busy, bus.done,
                 tbl_m[i], i, (i != TW - 1), (i == TW - 1));
      end
    end
    idle_inputs();
    exp_ones = (N+1)'($countones(tbl_m));
    vectors++;
    if (bus.ones !== exp_ones || bus.result !== tbl_m) begin
      errors++;
      $display("FAIL %s_summary: ones=%0d result=%h, required ones=%0d result=%h",
               tag, bus.ones, bus.result, exp_ones, tbl_m);
    end
  endtask

  task automatic test_sweep_init();
    run_sweep(1'b0, '0, 1'b0, "sweep_init");
    tick();
    vectors++;
    if (bus.done !== 1'b0 || bus.ones !== 5'd10 || bus.result !== INIT_TBL) begin
      errors++;
      $display("FAIL sweep_hold: done=%b ones=%0d result=%h, required done=0 ones=10 result=%h",
               bus.done, bus.ones, bus.result, INIT_TBL);
    end
  endtask

  task automatic test_sweep_single();
    direct_eval('0, 1'b1, 16'h8000, "load_8000");
    run_sweep(1'b0, '0, 1'b0, "sweep_8000");
    direct_eval('0, 1'b1, INIT_TBL, "load_init");
  endtask

  task automatic test_ignore_busy();
    run_sweep(1'b0, '0, 1'b1, "sweep_noise");
    vectors++;
    if (bus.ones !== 5'd10) begin
      errors++;
      $display("FAIL noise_ones: ones=%0d, required 10", bus.ones);
    end
    direct_eval(4'd15, 1'b0, '0, "frozen_x15");
  endtask

  task automatic test_load_with_start();
    run_sweep(1'b1, 16'hFFFF, 1'b0, "sweep_ffff");
    vectors++;
    if (bus.ones !== 5'd16) begin
      errors++;
      $display("FAIL ffff_ones: ones=%0d, required 16", bus.ones);
    end
  endtask

  task automatic test_back_to_back();
    run_sweep(1'b1, TW'($urandom), 1'b0, "b2b_a");
    run_sweep(1'b1, TW'($urandom), 1'b0, "b2b_b");
    run_sweep(1'b0, '0, 1'b1, "b2b_c");
    for (int k = 0; k < 3; k++) begin
      tick();
      run_sweep(1'b1, TW'($urandom), 1'($urandom), "rand_sweep");
    end
  endtask

  task automatic test_reset_mid_sweep();
    logic saw_done;
    direct_eval('0, 1'b1, 16'h8000, "load_pre_reset");
    bus.mode  = 1'b1;
    bus.start = 1'b1;
    tick();
    idle_inputs();
    for (int i = 0; i <= 5; i++) tick();
    vectors++;
    if (bus.vec !== 4'd5 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_position: vec=%0d busy=%b, required vec=5 busy=1", bus.vec, bus.busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("mid_reset_async");
    tbl_m = INIT_TBL;
    saw_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.done) saw_done = 1'b1;
    end
    vectors++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL mid_no_done: done pulse seen=%b, required 0", saw_done);
    end
    for (int i = 0; i < TW; i++) begin
      direct_eval(N'(i), 1'b0, '0, "post_reset_table");
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_direct();
    test_sweep_init();
    test_sweep_single();
    test_ignore_busy();
    test_load_with_start();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
